// File: rtl/em_alarm_monitor.sv
// EM sensor alarm monitor: synchronises the per-cell alarm lines, applies a
// mask, and tracks sticky status, a saturating event count and the first hit.
// A warm-up window after enable suppresses alarms while the cells settle, and
// a level interrupt is raised once the event count reaches the threshold.
module em_alarm_monitor #(
    parameter int WIDTH  = 32,
    parameter int WARMUP = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  alarm_in,
    input  logic              en,
    input  logic              mask_wr,
    input  logic [WIDTH-1:0]  mask_in,
    input  logic              clr,
    input  logic [CNT_W-1:0]  thresh,
    output logic [WIDTH-1:0]  sticky,
    output logic [CNT_W-1:0]  event_cnt,
    output logic [4:0]        first_idx,
    output logic              first_valid,
    output logic              irq,
    output logic [1:0]        state
);

    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARM    = 2'd1,
        ARMED   = 2'd2,
        TRIPPED = 2'd3
    } state_t;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Lowest set bit index; scanning downward lets the lowest index win.
    function automatic logic [4:0] lowest_idx(input logic [WIDTH-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    logic [WIDTH-1:0]  r_sync_p0;
    logic [WIDTH-1:0]  r_sync_p1;
    logic [WIDTH-1:0]  r_mask;
    logic [WIDTH-1:0]  r_sticky;
    logic [CNT_W-1:0]  r_cnt;
    logic [4:0]        r_fidx;
    logic              r_fvalid;
    logic              r_irq;
    logic [WARM_W-1:0] r_warm;
    state_t            r_state;

    state_t            w_state_nxt;
    logic [WIDTH-1:0]  w_hit;
    logic              w_any;
    logic              w_acc;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_trip;

    assign w_hit     = r_sync_p1 & ~r_mask;
    assign w_any     = |w_hit;
    // A hit is only accumulated while armed/tripped and enabled; clr discards it.
    assign w_acc     = w_any && en && !clr && (r_state == ARMED || r_state == TRIPPED);
    assign w_cnt_inc = sat_inc(r_cnt);
    assign w_trip    = (thresh != '0) && (w_cnt_inc >= thresh);

    // Two-flop synchroniser on the raw alarm lines (stage p0 -> p1).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= alarm_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Mask register; a write takes effect on the hit vector from the next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mask <= '0;
        end else if (mask_wr) begin
            r_mask <= mask_in;
        end
    end

    // Warm-up cycle counter, held at zero outside WARM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_warm <= '0;
        end else if (r_state == WARM) begin
            r_warm <= r_warm + 1'b1;
        end else begin
            r_warm <= '0;
        end
    end

    // State register and registered interrupt mirroring TRIPPED.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt == TRIPPED);
        end
    end

    // Next-state logic; dropping en returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = WARM;
                WARM: begin
                    if (r_warm == WARM_W'(WARMUP - 1)) w_state_nxt = ARMED;
                end
                ARMED: begin
                    if (w_acc && w_trip) w_state_nxt = TRIPPED;
                end
                TRIPPED: begin
                    if (clr) w_state_nxt = ARMED;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Status accumulation: sticky bits, saturating count and first-hit capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sticky <= '0;
            r_cnt    <= '0;
            r_fidx   <= '0;
            r_fvalid <= 1'b0;
        end else if (clr) begin
            r_sticky <= '0;
            r_cnt    <= '0;
            r_fidx   <= '0;
            r_fvalid <= 1'b0;
        end else if (w_acc) begin
            r_sticky <= r_sticky | w_hit;
            r_cnt    <= w_cnt_inc;
            if (!r_fvalid) begin
                r_fidx   <= lowest_idx(w_hit);
                r_fvalid <= 1'b1;
            end
        end
    end

    assign sticky      = r_sticky;
    assign event_cnt   = r_cnt;
    assign first_idx   = r_fidx;
    assign first_valid = r_fvalid;
    assign irq         = r_irq;
    assign state       = r_state;

endmodule

// File: tb/tb_em_alarm_monitor.sv
// Scoreboard bench for em_alarm_monitor: directed scenarios followed by random
// traffic, checked cycle by cycle against a behavioural model of the monitor.
module tb_em_alarm_monitor;

    localparam int WIDTH  = 32;
    localparam int WARMUP = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  alarm_in;
    logic              en;
    logic              mask_wr;
    logic [WIDTH-1:0]  mask_in;
    logic              clr;
    logic [CNT_W-1:0]  thresh;
    logic [WIDTH-1:0]  sticky;
    logic [CNT_W-1:0]  event_cnt;
    logic [4:0]        first_idx;
    logic              first_valid;
    logic              irq;
    logic [1:0]        state;

    em_alarm_monitor #(.WIDTH(WIDTH), .WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .alarm_in(alarm_in), .en(en),
        .mask_wr(mask_wr), .mask_in(mask_in), .clr(clr), .thresh(thresh),
        .sticky(sticky), .event_cnt(event_cnt), .first_idx(first_idx),
        .first_valid(first_valid), .irq(irq), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sticky;
        int          cnt;
        logic [4:0]  fidx;
        logic        fv;
        logic        irq;
        int          st;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model state (values holding before the next clock edge).
    int          m_state;        // 0 idle, 1 warm, 2 armed, 3 tripped
    int          m_warm_done;    // edges spent in warm-up so far
    logic [31:0] m_sticky;
    logic [31:0] m_mask;
    int          m_cnt;
    logic [4:0]  m_fidx;
    logic        m_fv;
    logic [31:0] m_hist[$];      // alarm samples, newest first

    task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, want);
    endtask

    // Drive one cycle of stimulus, advance the model over the coming edge and
    // queue the outputs expected after it.
    task automatic step(input logic r, input logic e, input logic [31:0] a,
                        input logic mw, input logic [31:0] mi,
                        input logic c, input logic [3:0] th);
        exp_t        x;
        logic [31:0] h;
        int          ns;
        @(negedge clk);
        rst = r; en = e; alarm_in = a; mask_wr = mw; mask_in = mi; clr = c; thresh = th;
        if (!r) begin
            m_state = 0; m_warm_done = 0; m_sticky = 0; m_mask = 0;
            m_cnt = 0; m_fidx = 0; m_fv = 0;
            m_hist = {32'h0, 32'h0};
        end else begin
            // The alarm sampled two edges ago is what the hit logic sees now.
            h  = m_hist[1] & ~m_mask;
            ns = m_state;
            if ((m_state == 2 || m_state == 3) && e && !c && h != 0) begin
                m_sticky = m_sticky | h;
                m_cnt    = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
                if (!m_fv) begin
                    int k = 0;
                    while (h[k] == 1'b0) k++;
                    m_fidx = 5'(k);
                    m_fv   = 1'b1;
                end
                if (m_state == 2 && th != 0 && m_cnt >= int'(th)) ns = 3;
            end
            if (c) begin
                m_sticky = 0; m_cnt = 0; m_fv = 0; m_fidx = 0;
                if (m_state == 3) ns = 2;
            end
            if (m_state == 0) begin
                ns = 1;
                m_warm_done = 0;
            end else if (m_state == 1) begin
                m_warm_done++;
                if (m_warm_done == WARMUP) ns = 2;
            end
            if (!e) ns = 0;
            m_state = ns;
            if (mw) m_mask = mi;
            void'(m_hist.pop_back());
            m_hist.push_front(a);
        end
        x.sticky = m_sticky; x.cnt = m_cnt; x.fidx = m_fidx; x.fv = m_fv;
        x.irq = (m_state == 3); x.st = m_state; x.cyc = cyc;
        exp_q.push_back(x);
        cyc++;
    endtask

    // Monitor: after each edge, compare the DUT outputs with the next expectation.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("sticky",      x.cyc, sticky,              x.sticky);
            chk("event_cnt",   x.cyc, 32'(event_cnt),      32'(x.cnt));
            chk("first_idx",   x.cyc, 32'(first_idx),      32'(x.fidx));
            chk("first_valid", x.cyc, 32'(first_valid),    32'(x.fv));
            chk("irq",         x.cyc, 32'(irq),            32'(x.irq));
            chk("state",       x.cyc, 32'(state),          32'(x.st));
        end
    end

    initial begin
        logic        r_en;
        logic [31:0] a, mi;
        logic [3:0]  th;
        rst = 1'b0; en = 1'b0; alarm_in = '0; mask_wr = 1'b0; mask_in = '0;
        clr = 1'b0; thresh = '0;

        // Reset with all alarms asserted, then idle with en low.
        repeat (3) step(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        repeat (4) step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);

        // Warm-up suppression: alarm held early in the window.
        for (int i = 0; i < 22; i++)
            step(1, 1, (i <= 10) ? 32'h0000_0010 : 32'h0, 0, 0, 0, 0);

        // Arm and capture, then a second pulse on bit 0.
        step(1, 1, 32'h0000_8810, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 32'h0000_0001, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0, 0);

        // Mask bit 0, threshold 3: masked pulses ignored, bit 7 trips on the third.
        step(1, 1, 0, 1, 32'h0000_0001, 1, 3);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h0000_0001, 0, 0, 0, 3);
            step(1, 1, 0, 0, 0, 0, 3);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h0000_0080, 0, 0, 0, 3);
            step(1, 1, 0, 0, 0, 0, 3);
        end
        repeat (2) step(1, 1, 0, 0, 0, 0, 3);

        // Clear priority: clr lands on the edge where a hit reaches the hit logic.
        step(1, 1, 32'h0000_0080, 0, 0, 0, 3);
        step(1, 1, 0, 0, 0, 0, 3);
        step(1, 1, 0, 0, 0, 1, 3);
        repeat (3) step(1, 1, 0, 0, 0, 0, 3);

        // Saturation with trip disabled, then drop enable.
        repeat (22) step(1, 1, 32'h0000_0080, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        r_en = 1'b1;
        th   = 4'd5;
        mi   = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) r_en = ~r_en;
            if ($urandom_range(0, 49) == 0)  th = 4'($urandom_range(0, 15));
            a = '0;
            if ($urandom_range(0, 3) == 0) a = 32'h1 << $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) a = a | $urandom();
            mi = $urandom() & $urandom() & $urandom();
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, r_en, a,
                 ($urandom_range(0, 29) == 0), mi,
                 ($urandom_range(0, 39) == 0), th);
        end
        repeat (2) step(1, 1, 0, 0, 0, 0, th);

        // Let the monitor drain the last expectation, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/em_alarm_monitor.md
Name: em_alarm_monitor

Overview:
- Aggregates the 32 per-cell alarm lines from the EM sensor array into a single monitored status.
- Provides per-bit sticky status, a saturating event counter and first-hit capture.
- A warm-up window suppresses alarms while sensor cells settle after enable.
- Raises a level interrupt once the event count reaches a programmable threshold; the interrupt and status are consumed by the coprocessor register interface.

Parameters:
WIDTH, 32, number of alarm lines (fixed at 32 for the array; first_idx is 5 bits)
WARMUP, 16, cycles of alarm suppression after entering warm-up (>=1)
CNT_W, 16, width of event counter and threshold

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
alarm_in  in  WIDTH  raw alarm vector from sensor array
en  in  1  monitor enable (level)
mask_wr  in  1  one-cycle strobe: load mask register
mask_in  in  WIDTH  mask value, 1 = line ignored
clr  in  1  one-cycle strobe: clear sticky, count, first-hit, trip
thresh  in  CNT_W  trip threshold; 0 = trip disabled
sticky  out  WIDTH  accumulated unmasked alarms
event_cnt  out  CNT_W  cycles with any unmasked alarm while armed/tripped
first_idx  out  5  lowest index of first captured hit
first_valid  out  1  first_idx is valid
irq  out  1  high while in TRIPPED
state  out  2  FSM state: IDLE=0, WARM=1, ARMED=2, TRIPPED=3

Behaviour:
- Reset (rst=0 at a clk edge, in any state including mid-operation):
  - state=IDLE.
  - sync flops, mask, sticky, event_cnt, first_idx, first_valid, irq and warm counter all 0.
- Synchroniser: two-flop chain per line, alarm_in -> s1 -> s2.
  - A pulse sampled at edge t is visible in s2 after edge t+1; it first affects outputs after edge t+2.
- hit = s2 & ~mask; any = |hit.
- mask_wr loads mask on that edge; the new mask applies to hit from the next cycle.
- FSM (en=0 in any non-IDLE state -> IDLE next edge; sticky, count and first-hit are retained):
  - IDLE: en=1 -> WARM, warm counter=0.
  - WARM: warm counter increments each cycle; hits are ignored. When counter==WARMUP-1 -> ARMED, so exactly WARMUP cycles are spent in WARM.
  - ARMED: if any, on the edge:
    - sticky |= hit.
    - event_cnt increments, saturating at 2^CNT_W-1.
    - if first_valid=0: first_idx = lowest set index of hit, first_valid=1.
    - if thresh!=0 and the new count >= thresh -> TRIPPED.
  - TRIPPED: accumulation continues as in ARMED; no further transition except via clr or en=0.
- irq is registered and equals (state==TRIPPED).
- clr:
  - Same edge: sticky=0, event_cnt=0, first_valid=0, first_idx=0.
  - TRIPPED -> ARMED; clr has no effect on state in WARM or IDLE.
  - clr wins over a same-cycle hit: that hit is discarded entirely (no sticky, count or capture).
- clr and en=0 on the same edge: both apply (clear, go IDLE).
- thresh is sampled live each cycle.
  - Lowering thresh to <= the current count while ARMED trips only on the next hit; there is no trip without a hit.
- Multiple bits on the first hit: first_idx takes the lowest index; all bits go to sticky.
- Outputs are registers; no combinational path from inputs to outputs.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles with alarm_in=FFFFFFFF -> all outputs 0, state=0; release rst with en=0 -> state stays 0, sticky=0.
- Warm-up suppression: en=1 at cycle 0, alarm_in=00000010 held for cycles 0..10, WARMUP=16 -> state=1 for exactly 16 cycles, sticky=0, event_cnt=0 throughout.
- Arm and capture: after ARMED, single-cycle alarm_in=00008810 -> two edges later sticky=00008810, event_cnt=1, first_idx=4, first_valid=1.
  - A second pulse alarm_in=00000001 -> sticky=00008811, first_idx stays 4.
- Mask and threshold: mask=00000001, thresh=3; pulse bit0 five times -> no change.
  - Then pulse bit7 three times -> event_cnt=3, state=3, irq=1 on the edge of the third count.
- Clear priority: in TRIPPED, assert clr together with a hit arriving at s2 -> next cycle sticky=0, event_cnt=0, first_valid=0, irq=0, state=2.
- Saturation and disable: CNT_W=4, thresh=0, alarm held continuously -> event_cnt reaches 15 and stays there, irq stays 0.
  - Drop en -> state=0, sticky retained.
